spi_master_tx: RTL and testbench

Serial transmit stage of the SPI master, sitting directly downstream of the TX word FIFO. It pops 32-bit words over a valid/ready handshake and shifts a programmed number of bits out on SDO while generating SCLK (mode 0: idle low, data changes on falling edge, sampled on rising edge). It stalls with SCLK low whenever the FIFO runs dry and pulses done when the programmed length has been sent.

---
 rtl/spi_master_tx.sv | 147 ++++++++++++++
 tb/tb_spi_master_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
// spi_master_tx: SPI mode-0 transmit shifter fed from a 32-bit word FIFO.
// Build option: define SPI_TX_LSB_FIRST_EN to shift LSB-first (default MSB-first).

module spi_master_tx #(
  parameter int CNT_WIDTH = 16,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [CNT_WIDTH-1:0] tx_len_i,
  input  logic [DIV_WIDTH-1:0] clk_div_i,
  input  logic [31:0]          data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 sclk_o,
  output logic                 sdo_o,
  output logic                 busy_o,
  output logic                 tx_done_o,
  output logic [1:0]           state_o
);

  // Handshake: a word moves on a rising clk edge where valid_i && ready_o.
  // ready_o depends only on the state, never on valid_i; the FIFO holds
  // valid_i/data_i stable until the word is taken.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] bits_left_q;
  logic [5:0]           word_bits_q;
  logic [5:0]           first_bits;
  logic [DIV_WIDTH-1:0] div_q, div_cnt_q;
  logic [31:0]          shreg_q;
  logic                 sclk_q;
  logic                 done_q, done_d;
  logic                 tick, fall;

  assign tick       = (state_q == SHIFT) && (div_cnt_q == div_q);
  assign fall       = tick && sclk_q;
  assign first_bits = (bits_left_q >= CNT_WIDTH'(32)) ? 6'd32 : bits_left_q[5:0];

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en_i) state_d = (tx_len_i != '0) ? WAIT_DATA : DONE;
      end
      WAIT_DATA: begin
        if (valid_i) state_d = SHIFT;
      end
      SHIFT: begin
        // Decisions use pre-decrement values, so "<= 1" means "last bit".
        if (fall) begin
          if (bits_left_q <= CNT_WIDTH'(1)) state_d = DONE;
          else if (word_bits_q <= 6'd1)     state_d = WAIT_DATA;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ready_o = 1'b0;
    busy_o  = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      IDLE:      busy_o  = 1'b0;
      WAIT_DATA: ready_o = 1'b1;
      DONE:      done_d  = 1'b1;
      default:   ;
    endcase
  end

  // Datapath: length/divider latches, divider counter, SCLK and shifter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bits_left_q <= '0;
      word_bits_q <= '0;
      div_q       <= '0;
      div_cnt_q   <= '0;
      shreg_q     <= '0;
      sclk_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= done_d;
      case (state_q)
        IDLE: begin
          if (en_i && (tx_len_i != '0)) begin
            bits_left_q <= tx_len_i;
            div_q       <= clk_div_i;
          end
        end
        WAIT_DATA: begin
          if (valid_i) begin
            shreg_q     <= data_i;
            word_bits_q <= first_bits;
            div_cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (tick) begin
            div_cnt_q <= '0;
            sclk_q    <= ~sclk_q;
            if (sclk_q) begin
              if (bits_left_q != '0) bits_left_q <= bits_left_q - CNT_WIDTH'(1);
              if (word_bits_q != '0) word_bits_q <= word_bits_q - 6'd1;
`ifdef SPI_TX_LSB_FIRST_EN
              shreg_q <= {1'b0, shreg_q[31:1]};
`else
              shreg_q <= {shreg_q[30:0], 1'b0};
`endif
            end
          end else begin
            div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_TX_LSB_FIRST_EN
  assign sdo_o = shreg_q[0];
`else
  assign sdo_o = shreg_q[31];
`endif

  assign sclk_o    = sclk_q;
  assign tx_done_o = done_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: table of transfers plus reset and
// ignored-enable sequences; SDO is scored against an expected bit queue.

module tb_spi_master_tx;

  localparam int LIMIT = 2000;

  logic        clk;
  logic        rst_ni;
  logic        en_i;
  logic [15:0] tx_len_i;
  logic [7:0]  clk_div_i;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic        sclk_o;
  logic        sdo_o;
  logic        busy_o;
  logic        tx_done_o;
  logic [1:0]  state_o;

  int tests;
  int fails;
  int rises;
  int pops;
  int dones;
  int hi_run;
  int hi_min;
  int hi_max;
  logic [0:0] exp_q[$];
  logic [0:0] exp_bit;

  typedef struct {
    logic [15:0] len;
    logic [7:0]  div;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    int          gap1;
    int          poke;
    int          exp_lat;
    int          exp_pops;
    int          exp_rises;
  } vec_t;

  vec_t vecs[7];

  spi_master_tx #(
    .CNT_WIDTH(16),
    .DIV_WIDTH(8)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .en_i      (en_i),
    .tx_len_i  (tx_len_i),
    .clk_div_i (clk_div_i),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .sclk_o    (sclk_o),
    .sdo_o     (sdo_o),
    .busy_o    (busy_o),
    .tx_done_o (tx_done_o),
    .state_o   (state_o)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each SCLK rise samples one bit against the expected queue
  always @(posedge sclk_o) begin
    rises++;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sdo_extra_bit: got rise %0d expected no more rises", rises);
    end else begin
      exp_bit = exp_q.pop_front();
      check("sdo_bit", sdo_o, exp_bit);
    end
  end

  always @(negedge clk) begin
    if (tx_done_o) dones++;
    if (sclk_o) hi_run++;
    else if (hi_run != 0) begin
      if (hi_run < hi_min) hi_min = hi_run;
      if (hi_run > hi_max) hi_max = hi_run;
      hi_run = 0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_ni && valid_i && ready_o) pops++;
  end

  task automatic clear_counters();
    rises  = 0;
    pops   = 0;
    dones  = 0;
    hi_run = 0;
    hi_min = 1000;
    hi_max = 0;
    exp_q.delete();
  endtask

  task automatic push_word(input logic [31:0] word, input int nb);
    for (int b = 0; b < nb; b++) begin
`ifdef SPI_TX_LSB_FIRST_EN
      exp_q.push_back(word[b]);
`else
      exp_q.push_back(word[31-b]);
`endif
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int rem;
    int lat;
    int nb;
    rem = int'(v.len);
    @(negedge clk);
    #1;
    clear_counters();
    for (int w = 0; w < v.nw; w++) begin
      nb = (rem >= 32) ? 32 : rem;
      push_word((w == 0) ? v.w0 : v.w1, nb);
      rem -= nb;
    end
    tx_len_i  = v.len;
    clk_div_i = v.div;
    en_i      = 1'b1;
    fork
      begin : driver
        int k;
        int stall_bad;
        for (int w = 0; w < v.nw; w++) begin
          k = 0;
          while (!ready_o && k < LIMIT) begin
            @(negedge clk);
            k++;
          end
          if (k >= LIMIT) begin
            check("ready_timeout", k, 0);
            break;
          end
          stall_bad = 0;
          if (w == 1) begin
            repeat (v.gap1) begin
              @(negedge clk);
              if (sclk_o !== 1'b0 || sdo_o !== 1'b0) stall_bad++;
            end
            if (v.gap1 > 0) check("stall_sclk_sdo_low", stall_bad, 0);
          end
          data_i  = (w == 0) ? v.w0 : v.w1;
          valid_i = 1'b1;
          @(posedge clk);
          #1;
          valid_i = 1'b0;
          data_i  = '0;
        end
      end
      begin : watcher
        @(negedge clk);
        en_i = 1'b0;
        lat  = 1;
        check("busy_after_start", busy_o, 1);
        while (!tx_done_o && lat < LIMIT) begin
          if (v.poke != 0 && lat == v.poke) begin
            en_i      = 1'b1;
            tx_len_i  = '0;
            clk_div_i = 8'd7;
          end else begin
            en_i = 1'b0;
          end
          @(negedge clk);
          lat++;
        end
        check("busy_at_done", busy_o, 0);
      end
    join
    repeat (3) @(negedge clk);
    $display("[TB] vector %0d: latency %0d rises %0d pops %0d", idx, lat, rises, pops);
    check("done_latency", lat, v.exp_lat);
    check("pop_count", pops, v.exp_pops);
    check("sclk_rises", rises, v.exp_rises);
    check("bits_left_unsent", exp_q.size(), 0);
    check("done_pulses", dones, 1);
    check("idle_after", state_o, 2'd0);
    if (v.len != 0) begin
      check("sclk_high_min", hi_min, int'(v.div) + 1);
      check("sclk_high_max", hi_max, int'(v.div) + 1);
    end
  endtask

  initial begin
    int k;
    // len, div, nw, w0, w1, gap1, poke, exp_lat, exp_pops, exp_rises
    vecs[0] = '{16'd32, 8'd0, 1, 32'hA5A5_0F0F, 32'h0,         0,  0,  67, 1, 32};
    vecs[1] = '{16'd40, 8'd0, 2, 32'hDEAD_BEEF, 32'hC300_0000, 0,  0,  84, 2, 40};
    vecs[2] = '{16'd64, 8'd0, 2, 32'h1234_5678, 32'h9ABC_DEF0, 50, 0, 182, 2, 64};
    vecs[3] = '{16'd8,  8'd3, 1, 32'h5A00_0000, 32'h0,         0,  0,  67, 1, 8};
    vecs[4] = '{16'd33, 8'd1, 2, 32'hFFFF_FFFF, 32'h8000_0000, 0,  0, 136, 2, 33};
    vecs[5] = '{16'd0,  8'd0, 0, 32'h0,         32'h0,         0,  0,   2, 0, 0};
    vecs[6] = '{16'd32, 8'd0, 1, 32'h0F0F_00FF, 32'h0,         0, 20,  67, 1, 32};

    tests     = 0;
    fails     = 0;
    rst_ni    = 1'b0;
    en_i      = 1'b0;
    tx_len_i  = '0;
    clk_div_i = '0;
    data_i    = '0;
    valid_i   = 1'b0;
    clear_counters();
    repeat (3) @(negedge clk);
    check("reset_outputs", {sclk_o, sdo_o, ready_o, busy_o, tx_done_o, state_o}, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {sclk_o, ready_o, busy_o, tx_done_o, state_o}, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset in the middle of bit 10, then a fresh transfer
    @(negedge clk);
    #1;
    clear_counters();
    push_word(32'hA5A5_0F0F, 32);
    tx_len_i  = 16'd32;
    clk_div_i = 8'd0;
    data_i    = 32'hA5A5_0F0F;
    valid_i   = 1'b1;
    en_i      = 1'b1;
    @(negedge clk);
    en_i = 1'b0;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    k = 0;
    while (rises < 10 && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    check("reached_bit10", rises, 10);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_midbit_outputs", {sclk_o, sdo_o, ready_o, busy_o, tx_done_o, state_o}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("rst_held_outputs", {sclk_o, sdo_o, ready_o, busy_o, tx_done_o, state_o}, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("rst_idle_no_done", {tx_done_o, busy_o, state_o}, 0);
    check("rst_one_pop", pops, 1);
    run_vec(vecs[0], 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
